// File: rtl/fase_ctrl.sv
// fase_ctrl: phase-sequencing controller sitting in front of the 5-phase
// one-hot phase counter. It owns the current phase, only accepts the
// counter's answer when it is the legal successor, stalls the memory phase
// on a request/ack handshake (with timeout), traps illegal counter values
// into a sticky error state and counts retired instructions.
// Optional build macro: FASE_CTRL_PERF_EN enables the memory-stall counter;
// without it stall_count reads as zero and no counter logic exists.
module fase_ctrl #(
    parameter int CNT_W       = 16,
    parameter int TO_W        = 8,
    parameter int MEM_TIMEOUT = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             halt_req,
    input  logic             mem_use,
    input  logic             mem_ack,
    input  logic [4:0]       next_fase,
    output logic [4:0]       cur_fase,
    output logic [4:0]       fase_en,
    output logic             mem_req,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] inst_count,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [4:0]      PH_MEM    = 5'b01000;
    localparam logic [4:0]      PH_WB     = 5'b10000;
    localparam logic [TO_W-1:0] TO_LIMIT  = TO_W'(MEM_TIMEOUT);
    localparam bit              TO_ENABLE = (MEM_TIMEOUT != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_WAIT_MEM,
        S_ERR
    } state_t;

    state_t           state_q, state_d;
    logic [4:0]       cur_fase_q, cur_fase_d;
    logic [4:0]       fase_en_q, fase_en_d;
    logic             mem_req_q, mem_req_d;
    logic             err_q, err_d;
    logic             halt_pend_q, halt_pend_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0] inst_count_q, inst_count_d;

    logic [4:0]       rot_cur;
    logic             phase_ok;
    logic             bad;
    logic [TO_W-1:0]  to_cnt_inc;
    logic             timeout_hit;

    // Legal successor of the current phase, counter sanity and timeout detection.
    always_comb begin
        rot_cur     = (cur_fase_q == 5'b00000 || cur_fase_q == PH_WB) ? 5'b00001
                                                                      : {cur_fase_q[3:0], 1'b0};
        phase_ok    = (next_fase == rot_cur);
        // More than one bit set; all-zero is tolerated (counter idle).
        bad         = ((next_fase & (next_fase - 5'd1)) != 5'd0);
        to_cnt_inc  = (to_cnt_q == '1) ? to_cnt_q : to_cnt_q + TO_W'(1);
        timeout_hit = TO_ENABLE && (to_cnt_inc == TO_LIMIT);
    end

    // Next-state and next-output logic of the sequencing FSM.
    always_comb begin
        state_d      = state_q;
        cur_fase_d   = cur_fase_q;
        fase_en_d    = 5'b00000;
        mem_req_d    = mem_req_q;
        err_d        = err_q;
        halt_pend_d  = halt_pend_q;
        to_cnt_d     = to_cnt_q;
        inst_count_d = inst_count_q;

        // A halt request is remembered until the next retire, never acted on mid-instruction.
        if (state_q != S_IDLE && halt_req) begin
            halt_pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                cur_fase_d  = 5'b00000;
                halt_pend_d = 1'b0;
                if (run) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (bad) begin
                    err_d     = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = S_ERR;
                end else if (phase_ok) begin
                    if (cur_fase_q == PH_WB) begin
                        inst_count_d = inst_count_q + CNT_W'(1);
                    end
                    if (cur_fase_q == PH_WB && (halt_pend_q || halt_req)) begin
                        // Retire and park: no strobe for the phase we decline to start.
                        cur_fase_d  = 5'b00000;
                        halt_pend_d = 1'b0;
                        state_d     = S_IDLE;
                    end else begin
                        cur_fase_d = next_fase;
                        fase_en_d  = next_fase;
                        if (next_fase == PH_MEM && mem_use) begin
                            mem_req_d = 1'b1;
                            to_cnt_d  = '0;
                            state_d   = S_WAIT_MEM;
                        end
                    end
                end
            end
            S_WAIT_MEM: begin
                to_cnt_d = to_cnt_inc;
                // Timeout wins over a simultaneous ack: the transaction is declared lost.
                if (bad || timeout_hit) begin
                    err_d     = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = S_ERR;
                end else if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = S_RUN;
                end
            end
            default: begin
                // S_ERR: everything frozen until reset.
            end
        endcase
    end

    // State and output registers, cleared asynchronously by the active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cur_fase_q   <= 5'b00000;
            fase_en_q    <= 5'b00000;
            mem_req_q    <= 1'b0;
            err_q        <= 1'b0;
            halt_pend_q  <= 1'b0;
            to_cnt_q     <= '0;
            inst_count_q <= '0;
        end else begin
            state_q      <= state_d;
            cur_fase_q   <= cur_fase_d;
            fase_en_q    <= fase_en_d;
            mem_req_q    <= mem_req_d;
            err_q        <= err_d;
            halt_pend_q  <= halt_pend_d;
            to_cnt_q     <= to_cnt_d;
            inst_count_q <= inst_count_d;
        end
    end

    assign cur_fase   = cur_fase_q;
    assign fase_en    = fase_en_q;
    assign mem_req    = mem_req_q;
    assign err        = err_q;
    assign busy       = (state_q != S_IDLE);
    assign inst_count = inst_count_q;

`ifdef FASE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    // Memory-wait cycle count, saturating so long runs never appear to have few stalls.
    always_comb begin
        stall_count_d = stall_count_q;
        if (state_q == S_WAIT_MEM && stall_count_q != '1) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    // Stall counter register, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: doc/fase_ctrl.md
Name: fase_ctrl

Overview:
- Phase-sequencing controller directly upstream of the 5-phase one-hot phase counter.
- Holds the current phase register and drives it into the counter's past-phase input.
- Advances to the counter's returned next phase only when allowed: run/halt, memory-wait handshake, error detection.
- Emits one-cycle per-phase enable strobes to the datapath and counts retired instructions.

Parameters:
CNT_W, 16, width of retired-instruction counter
TO_W, 8, width of memory-wait timeout counter
MEM_TIMEOUT, 200, max cycles waiting for mem_ack; 0 disables timeout

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; asynchronous, active-low (asserted when 0)
run  in  1  level; start/continue sequencing from IDLE
halt_req  in  1  pulse/level; stop after current instruction's writeback
mem_use  in  1  current instruction needs memory phase handshake; sampled on entry to phase 01000
mem_ack  in  1  memory transaction complete
next_fase  in  5  next phase returned by phase counter
cur_fase  out  5  current phase to phase counter past-phase input
fase_en  out  5  one-cycle strobe, bit i = phase bit i just entered
mem_req  out  1  memory request, level, held until ack
busy  out  1  1 when state != IDLE
err  out  1  sticky error flag
inst_count  out  CNT_W  retired instructions, wraps
stall_count  out  CNT_W  memory-wait cycles (see Optional Feature)

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; cur_fase=00000; fase_en=0; mem_req=0; err=0; inst_count=0; stall_count=0; halt_pend=0.
- rot(x): 00000->00001, 00001->00010, 00010->00100, 00100->01000, 01000->10000, 10000->00001.
- phase_ok = (next_fase == rot(cur_fase)). Counter is registered, so next_fase lags cur_fase by one cycle; each phase lasts >=2 cycles.
- bad = next_fase not one-hot and != 00000.
- States: IDLE, RUN, WAIT_MEM, ERR.
- IDLE:
  - cur_fase=00000, no strobes.
  - run=1 -> RUN on the next edge.
- RUN, per edge:
  - If phase_ok: cur_fase<=next_fase and fase_en<=next_fase for exactly one cycle.
  - Otherwise cur_fase holds and fase_en=0.
- Entering 01000 with mem_use=1:
  - mem_req<=1; state->WAIT_MEM.
  - Timeout counter cleared.
- WAIT_MEM:
  - cur_fase held regardless of next_fase.
  - mem_ack=1: mem_req<=0, state->RUN; advance permitted from the following edge.
  - mem_ack already high on the entry cycle is not consumed; earliest ack is the first WAIT_MEM cycle.
  - Timeout counter increments each WAIT_MEM cycle. When it reaches MEM_TIMEOUT (MEM_TIMEOUT!=0): err<=1, mem_req<=0, state->ERR.
- Writeback retire: in RUN with cur_fase=10000 and phase_ok, inst_count<=inst_count+1 (wraps at 2^CNT_W).
  - If halt_pend or halt_req is set at that edge: cur_fase<=00000, no strobe, halt_pend<=0, state->IDLE.
  - Otherwise advance to 00001 normally.
- halt_req:
  - Captured into sticky halt_pend in any non-IDLE state.
  - Ignored in IDLE.
  - Never aborts a phase.
- bad=1 in RUN or WAIT_MEM: err<=1, state->ERR, mem_req<=0.
- ERR: cur_fase, inst_count frozen; fase_en=0; only reset exits.
- Simultaneous events:
  - bad beats everything.
  - Timeout beats mem_ack on the same edge.
  - halt at retire beats run.
- busy is combinational from state.

Optional Feature:
- FASE_CTRL_PERF_EN defined:
  - stall_count increments each cycle in WAIT_MEM, saturating at all-ones.
  - Cleared only by reset.
- Not defined: stall_count tied to 0; no counter logic synthesised.

Test Plan:
- Reset release, run=1, ideal counter model, mem_use=0 -> cur_fase 00001,00010,00100,01000,10000,00001 every 2 cycles; one fase_en pulse per phase; inst_count=1 after first 10000->00001.
- mem_use=1, mem_ack after 5 cycles -> cur_fase held at 01000 for 5 WAIT_MEM cycles; mem_req high exactly until ack edge; 10000 entered 2 cycles after ack; stall_count=5 with FASE_CTRL_PERF_EN, 0 without.
- halt_req pulse during phase 00010 -> instruction completes; after the 10000 retire, cur_fase=00000, busy=0, inst_count+1, no 00001 strobe; run=1 resumes at 00001.
- MEM_TIMEOUT=4, mem_use=1, no ack -> err=1 after 4 WAIT_MEM cycles, mem_req=0, state frozen; rst=0 clears err.
- Force next_fase=00110 in RUN -> err=1 next edge, fase_en stays 0; same cycle as mem_ack -> still ERR.
- Assert rst=0 mid-WAIT_MEM, asynchronously between edges -> all outputs zero immediately, before the next clock edge.
